secure_reg_initiator: RTL and testbench
=======================================

# secure_reg_initiator

Bus-side initiator that sits in front of `secure_register` and serialises access requests from up to `NUM_THREADS` software threads onto that register's single `access_en`/`wr_en`/`thread_id` port. It arbitrates round-robin and enforces the thread-0-only policy before anything reaches the register. Every request gets exactly one response with an error flag, and a run of denied attempts trips a sticky lockout. There is no debug, bypass, or test mode: every behaviour of the block is listed below.

## Interface
- `DATA_WIDTH`, 32, register data width
- `NUM_THREADS`, 4, number of requesting threads (≥2)
- `TID_WIDTH`, 2, width of thread id, equal to $clog2(NUM_THREADS)
- `LOCKOUT_LIMIT`, 3, consecutive denied requests that trip lockout (≥1)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_THREADS  per-thread request valid
- `req_ready`  out  NUM_THREADS  per-thread accept, one-hot or zero
- `req_wr`  in  NUM_THREADS  per-thread: 1 = write, 0 = read
- `req_wdata`  in  NUM_THREADS*DATA_WIDTH  per-thread write data; thread i uses slice [i*DATA_WIDTH +: DATA_WIDTH]
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response accept
- `rsp_tid`  out  TID_WIDTH  thread the response belongs to
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes and errors
- `rsp_err`  out  1  request denied
- `reg_access_en`  out  1  register access strobe
- `reg_wr_en`  out  1  register write strobe
- `reg_thread_id`  out  TID_WIDTH  id presented to the register
- `reg_data_in`  out  DATA_WIDTH  write data to the register
- `reg_data_out`  in  DATA_WIDTH  read data from the register, valid the cycle after the access
- `lockout`  out  1  sticky lockout flag

## Operation
- FSM states are `IDLE`, `GRANT`, `ACCESS`, `WAIT`, `RESP`.
- **IDLE:** any `req_valid` bit set → `GRANT`.
- **GRANT:** the arbiter picks index g. The block drives `req_ready[g]`=1 for this one cycle and captures tid=g, `req_wr[g]` and the g-th data slice.
  - If g==0 and `lockout`=0, the request is permitted → `ACCESS`.
  - Otherwise the request is denied → `RESP` with `rsp_err`=1.
- **ACCESS:** drive `reg_access_en`=1, `reg_wr_en`=captured wr, `reg_thread_id`=0, `reg_data_in`=captured data, for one cycle. Next state is `WAIT`.
- **WAIT:** capture `reg_data_out` into `rsp_rdata` if the request was a read, else load 0. Next state is `RESP`.
- **RESP:** hold `rsp_valid`=1 and all `rsp_*` stable until `rsp_ready`=1, then → `IDLE`.
- Arbiter: round-robin with pointer p, which resets to 0. It grants the first set `req_valid` bit at or after p, cyclically. After a grant at g, p becomes (g+1) mod NUM_THREADS.
- Denial counter:
  - Increments on each denied grant, saturating at `LOCKOUT_LIMIT`.
  - Clears to 0 on each permitted grant.
  - `lockout` becomes 1 on the same edge the counter reaches `LOCKOUT_LIMIT`, and stays 1 until `rst`.
- When `lockout`=1, thread 0 is denied too. The block asserts no `reg_*` strobe while locked out.
- The `reg_*` outputs are 0 in every state except `ACCESS`. A denied request never produces a register strobe.

## Timing
- Every output resets to 0: `req_ready`, `rsp_*`, `reg_*`, `lockout`. FSM resets to `IDLE`; arbiter pointer and denial counter reset to 0.
- Permitted read with request first seen in `IDLE` at cycle t:
  - `req_ready` at t+1
  - `reg_access_en` at t+2
  - `rsp_valid` at t+4
- Denied request: `req_ready` at t+1, `rsp_valid` at t+2.
- With `rsp_ready` held high, back-to-back permitted requests issue every 5 cycles; denied requests every 3 cycles.
- A request is accepted only on the `req_valid`&`req_ready` cycle. Dropping `req_valid` before grant is legal and produces no response.
- Asserting `rst` in any state aborts the in-flight request with no response and no further strobe. Outputs are 0 on the next cycle.

## Structure
- Package `secure_reg_pkg` holds the FSM state enum and the constant `SECURE_TID = 0`, shared with `secure_register`.
- Sub-module `rr_arbiter` (parameter `N`) takes `req[N]` and an `advance` input, and returns one-hot `grant` plus the encoded index. It holds the round-robin pointer.

## Test plan
- Thread 0 writes 0xDEADBEEF, then reads → exactly one `reg_access_en` pulse with `reg_wr_en`=1, `reg_data_in`=0xDEADBEEF. The read returns `rsp_rdata`=0xDEADBEEF, `rsp_err`=0, `rsp_valid` at t+4.
- Thread 2 reads → `rsp_err`=1, `rsp_tid`=2, `rsp_rdata`=0, `rsp_valid` at t+2, `reg_access_en` never asserted.
- Threads 0–3 all valid continuously → grants in order 0,1,2,3,0. Denial counter: 1,2 after threads 1,2; `lockout` trips at thread 3's grant. The following thread 0 request gets `rsp_err`=1.
- Thread 1 denied twice, then a thread 0 grant, then thread 1 denied twice more → counter clears on the thread 0 grant, so `lockout` stays 0.
- `rsp_ready` held low for 10 cycles in `RESP` → `rsp_*` stable for all 10 cycles, `req_ready` stays 0, and there is one response.
- `rst` asserted in the `ACCESS` cycle → all outputs 0 next cycle, no `rsp_valid`, `lockout`=0. The next thread 0 read completes normally.

Source files
------------

// File: rtl/secure_reg_pkg.sv
// Shared definitions for the secure register and its bus-side initiator.
package secure_reg_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GRANT  = 3'd1,
        ACCESS = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_e;

    // Only this thread is ever allowed to touch the secure register.
    localparam int unsigned SECURE_TID = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, cyclically.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IW'((32'(ptr_q) + i) % N);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && grant_valid) begin
            ptr_d = (32'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/secure_reg_initiator.sv
// Serialises per-thread requests onto the secure register port, enforcing the
// thread-0-only policy and a sticky lockout after repeated denied attempts.
module secure_reg_initiator
    import secure_reg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned NUM_THREADS   = 4,
    parameter int unsigned TID_WIDTH     = 2,
    parameter int unsigned LOCKOUT_LIMIT = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_THREADS-1:0]            req_valid,
    output logic [NUM_THREADS-1:0]            req_ready,
    input  logic [NUM_THREADS-1:0]            req_wr,
    input  logic [NUM_THREADS*DATA_WIDTH-1:0] req_wdata,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [TID_WIDTH-1:0]              rsp_tid,
    output logic [DATA_WIDTH-1:0]             rsp_rdata,
    output logic                              rsp_err,
    output logic                              reg_access_en,
    output logic                              reg_wr_en,
    output logic [TID_WIDTH-1:0]              reg_thread_id,
    output logic [DATA_WIDTH-1:0]             reg_data_in,
    input  logic [DATA_WIDTH-1:0]             reg_data_out,
    output logic                              lockout
);

    localparam int unsigned CNT_W = $clog2(LOCKOUT_LIMIT + 1);

    if (TID_WIDTH != $clog2(NUM_THREADS)) begin : g_bad_tid_width
        $error("TID_WIDTH must equal $clog2(NUM_THREADS)");
    end
    if (NUM_THREADS < 2 || LOCKOUT_LIMIT < 1) begin : g_bad_params
        $error("NUM_THREADS must be >= 2 and LOCKOUT_LIMIT >= 1");
    end

    state_e                  state_q, state_d;
    logic [TID_WIDTH-1:0]    tid_q, tid_d;
    logic                    wr_q, wr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    lockout_q, lockout_d;

    logic [NUM_THREADS-1:0]  arb_grant;
    logic [TID_WIDTH-1:0]    arb_idx;
    logic                    arb_valid;
    logic                    arb_advance;
    logic                    permit;

    assign arb_advance = (state_q == GRANT);
    // Lockout revokes thread 0's privilege as well.
    assign permit      = (arb_idx == TID_WIDTH'(SECURE_TID)) && !lockout_q;

    rr_arbiter #(
        .N (NUM_THREADS)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (req_valid),
        .advance     (arb_advance),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tid_q     <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            lockout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tid_q     <= tid_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            lockout_q <= lockout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tid_d     = tid_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        lockout_d = lockout_q;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Requester may have withdrawn before the grant cycle.
                if (arb_valid) begin
                    tid_d   = arb_idx;
                    wr_d    = req_wr[arb_idx];
                    wdata_d = req_wdata[arb_idx*DATA_WIDTH +: DATA_WIDTH];
                    rdata_d = '0;
                    if (permit) begin
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = ACCESS;
                    end else begin
                        err_d = 1'b1;
                        if (cnt_q < CNT_W'(LOCKOUT_LIMIT)) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (cnt_d == CNT_W'(LOCKOUT_LIMIT)) begin
                            lockout_d = 1'b1;
                        end
                        state_d = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d = WAIT;
            end
            WAIT: begin
                rdata_d = wr_q ? '0 : reg_data_out;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready     = '0;
        rsp_valid     = 1'b0;
        rsp_tid       = '0;
        rsp_rdata     = '0;
        rsp_err       = 1'b0;
        reg_access_en = 1'b0;
        reg_wr_en     = 1'b0;
        reg_thread_id = '0;
        reg_data_in   = '0;
        unique case (state_q)
            GRANT: begin
                req_ready = arb_grant;
            end
            ACCESS: begin
                reg_access_en = 1'b1;
                reg_wr_en     = wr_q;
                reg_thread_id = TID_WIDTH'(SECURE_TID);
                reg_data_in   = wdata_q;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_tid   = tid_q;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
            end
            default: ;
        endcase
    end

    assign lockout = lockout_q;

endmodule

// File: tb/tb_secure_reg_initiator.sv
// Directed self-checking bench for secure_reg_initiator with a simple register model.
module tb_secure_reg_initiator;

    localparam int DW = 32;
    localparam int NT = 4;
    localparam int TW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NT-1:0]    req_valid = '0;
    logic [NT-1:0]    req_ready;
    logic [NT-1:0]    req_wr = '0;
    logic [NT*DW-1:0] req_wdata = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [TW-1:0]    rsp_tid;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;
    logic             reg_access_en;
    logic             reg_wr_en;
    logic [TW-1:0]    reg_thread_id;
    logic [DW-1:0]    reg_data_in;
    logic [DW-1:0]    reg_data_out;
    logic             lockout;

    logic [DW-1:0]    mem = '0;
    logic [DW-1:0]    rd_q = '0;
    int               access_cnt = 0;
    int               snap;
    int               checks = 0;
    int               failures = 0;

    always #5 clk = ~clk;

    secure_reg_initiator #(
        .DATA_WIDTH    (DW),
        .NUM_THREADS   (NT),
        .TID_WIDTH     (TW),
        .LOCKOUT_LIMIT (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wr        (req_wr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_tid       (rsp_tid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .reg_access_en (reg_access_en),
        .reg_wr_en     (reg_wr_en),
        .reg_thread_id (reg_thread_id),
        .reg_data_in   (reg_data_in),
        .reg_data_out  (reg_data_out),
        .lockout       (lockout)
    );

    // Register model: read data appears the cycle after the access strobe.
    always @(posedge clk) begin
        if (reg_access_en) begin
            access_cnt <= access_cnt + 1;
            if (reg_wr_en) mem <= reg_data_in;
            else rd_q <= mem;
        end
    end
    assign reg_data_out = rd_q;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {req_ready, rsp_valid, rsp_tid, rsp_rdata, rsp_err, reg_access_en,
                reg_wr_en, reg_thread_id, reg_data_in, lockout};
    endfunction

    // One request from a single thread with rsp_ready high; checks every cycle.
    task automatic txn(input int tid, input bit wr, input logic [DW-1:0] wd,
                       input bit exp_err, input logic [DW-1:0] exp_rdata, input string tag);
        req_valid = '0;
        req_valid[tid] = 1'b1;
        req_wr = '0;
        req_wr[tid] = wr;
        req_wdata[tid*DW +: DW] = wd;
        step();
        chk({tag, "_ready"}, req_ready, 4'b0001 << tid);
        chk({tag, "_early_rsp"}, rsp_valid, 0);
        step();
        req_valid = '0;
        if (!exp_err) begin
            chk({tag, "_access"}, reg_access_en, 1);
            chk({tag, "_wr_en"}, reg_wr_en, wr);
            chk({tag, "_data_in"}, reg_data_in, wd);
            chk({tag, "_reg_tid"}, reg_thread_id, 0);
            step();
            chk({tag, "_wait_access"}, reg_access_en, 0);
            chk({tag, "_wait_rsp"}, rsp_valid, 0);
            step();
        end
        chk({tag, "_rsp_valid"}, rsp_valid, 1);
        chk({tag, "_rsp_err"}, rsp_err, exp_err);
        chk({tag, "_rsp_tid"}, rsp_tid, tid);
        chk({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, "_rsp_strobe"}, reg_access_en, 0);
        step();
        chk({tag, "_rsp_done"}, rsp_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        chk("reset_outputs", all_outs(), 0);
        rst = 1'b0;
        step();
        chk("idle_outputs", all_outs(), 0);

        // Thread 0 write then read back.
        snap = access_cnt;
        txn(0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, "t0_write");
        txn(0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, "t0_read");
        chk("t0_access_pulses", access_cnt - snap, 2);

        // Thread 2 is denied without touching the register.
        snap = access_cnt;
        txn(2, 1'b0, 32'h5555_AAAA, 1'b1, 32'h0, "t2_denied");
        chk("t2_no_access", access_cnt - snap, 0);
        chk("t2_lockout", lockout, 0);

        // Response back-pressure: thread 0 read held in RESP for 10 cycles.
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        req_wr = '0;
        step();
        chk("bp_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        step();
        step();
        req_valid = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
            chk("bp_rsp_err_tid", {rsp_err, rsp_tid}, 0);
            chk("bp_req_ready", req_ready, 0);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        chk("bp_released", rsp_valid, 0);
        step();
        chk("bp_single_rsp", rsp_valid, 0);

        // Counter clears on a permitted grant, so two-plus-two denials never lock.
        txn(1, 1'b0, 32'h0, 1'b1, 32'h0, "t1_deny_a");
        txn(1, 1'b0, 32'h0, 1'b1, 32'h0, "t1_deny_b");
        chk("clear_pre_lockout", lockout, 0);
        txn(0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, "t0_clear");
        txn(1, 1'b0, 32'h0, 1'b1, 32'h0, "t1_deny_c");
        txn(1, 1'b0, 32'h0, 1'b1, 32'h0, "t1_deny_d");
        chk("clear_lockout", lockout, 0);

        // Reset during ACCESS aborts the request.
        req_valid = 4'b0001;
        req_wr = '0;
        step();
        step();
        req_valid = '0;
        chk("abort_in_access", reg_access_en, 1);
        rst = 1'b1;
        step();
        chk("abort_outputs", all_outs(), 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_no_rsp", {rsp_valid, reg_access_en}, 0);
        end
        txn(0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, "post_abort_read");

        // All four threads continuously valid from a fresh reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        snap = access_cnt;
        req_valid = 4'hF;
        req_wr = '0;
        step();
        chk("rr_ready_0", req_ready, 4'b0001);
        step();
        step();
        step();
        chk("rr_rsp_0", {rsp_valid, rsp_err, rsp_tid}, {1'b1, 1'b0, 2'd0});
        chk("rr_rdata_0", rsp_rdata, 32'hDEAD_BEEF);
        step();
        for (int g = 1; g < 4; g++) begin
            step();
            chk("rr_ready", req_ready, 4'b0001 << g);
            step();
            chk("rr_rsp", {rsp_valid, rsp_err, rsp_tid}, {1'b1, 1'b1, 2'(g)});
            chk("rr_lockout", lockout, (g == 3));
            step();
        end
        step();
        chk("rr_ready_wrap", req_ready, 4'b0001);
        step();
        chk("locked_t0_rsp", {rsp_valid, rsp_err, rsp_tid}, {1'b1, 1'b1, 2'd0});
        chk("locked_t0_rdata", rsp_rdata, 0);
        chk("rr_access_pulses", access_cnt - snap, 1);
        req_valid = '0;
        step();
        chk("lockout_sticky", lockout, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
